// File: rtl/lsu_axi_master_if.sv
// AXI-lite read/write channel bundle between the LSU back end and the data SRAM slave.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// LSU back end: one core load/store request -> one AXI-lite transaction, one outstanding.
// Optional memory trace printed when LSU_MTRACE_EN is defined.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  lsu_axi_master_if.master  axi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

`ifdef LSU_MTRACE_EN
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
`endif

  logic [2:0]          state;
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                aw_done;
  logic                w_done;
  logic                misaligned;
  logic [DATA_W-1:0]   lane_data;
  logic [DATA_W/8-1:0] lane_strb;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_data;
  logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_DONE);
  assign axi.arvalid = (state == S_RADDR);
  assign axi.rready  = (state == S_RDATA);
  assign axi.awvalid = (state == S_WRITE) && !aw_done;
  assign axi.wvalid  = (state == S_WRITE) && !w_done;
  assign axi.bready  = (state == S_WRESP);

  assign ar_hs = axi.arvalid & axi.arready;
  assign r_hs  = axi.rvalid  & axi.rready;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;
  assign b_hs  = axi.bvalid  & axi.bready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_data = req_wdata;
    lane_strb = '1;
    case (req_size)
      2'b00: begin
        lane_data = {4{req_wdata[7:0]}};
        lane_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        lane_data = {2{req_wdata[15:0]}};
        lane_strb = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  // Returned word is shifted so the addressed byte sits in lane 0 before extension.
  always_comb begin
    shifted   = axi.rdata >> {r_off, 3'b000};
    load_data = shifted;
    case (r_size)
      2'b00:   load_data = r_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = r_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      axi.araddr <= '0;
      axi.awaddr <= '0;
      axi.wdata  <= '0;
      axi.wstrb  <= '0;
`ifdef LSU_MTRACE_EN
      r_addr     <= '0;
      r_wdata    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          r_off  <= req_addr[1:0];
          r_size <= req_size;
          r_uns  <= req_unsigned;
`ifdef LSU_MTRACE_EN
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
`endif
          if (misaligned) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= S_DONE;
          end else if (req_we) begin
            axi.awaddr <= {req_addr[ADDR_W-1:2], 2'b00};
            axi.wdata  <= lane_data;
            axi.wstrb  <= lane_strb;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            state      <= S_WRITE;
          end else begin
            axi.araddr <= {req_addr[ADDR_W-1:2], 2'b00};
            state      <= S_RADDR;
          end
        end
        S_RADDR: if (ar_hs) state <= S_RDATA;
        S_RDATA: if (r_hs) begin
          resp_err   <= |axi.rresp;
          resp_rdata <= (axi.rresp == 2'b00) ? load_data : '0;
          state      <= S_DONE;
`ifdef LSU_MTRACE_EN
          $display("MTRACE is_write=%0d addr=%h data=%h size=%0d", 1'b0, r_addr, load_data, r_size);
`endif
        end
        S_WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_WRESP;
        end
        S_WRESP: if (b_hs) begin
          resp_err   <= |axi.bresp;
          resp_rdata <= '0;
          state      <= S_DONE;
`ifdef LSU_MTRACE_EN
          $display("MTRACE is_write=%0d addr=%h data=%h size=%0d", 1'b1, r_addr, r_wdata, r_size);
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the bench plays the AXI-lite slave cycle by cycle.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle; on return we are in the first cycle after accept.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns, input string tag);
    @(negedge clk);
    check({tag, "/req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    check({tag, "/resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "/resp_rdata"}, resp_rdata, exp_rd);
    check({tag, "/resp_err"},   {31'b0, resp_err},   {31'b0, exp_err});
    @(negedge clk);
    check({tag, "/pulse_end"},  {31'b0, resp_valid}, 32'd0);
    check({tag, "/idle"},       {31'b0, req_ready},  32'd1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                         input int ar_delay, input int r_delay,
                         input logic [31:0] exp_araddr, input logic [31:0] exp_rd,
                         input logic exp_err);
    issue(1'b0, addr, 32'h0, size, uns, tag);
    check({tag, "/arvalid"}, {31'b0, axi.arvalid}, 32'd1);
    check({tag, "/araddr"},  axi.araddr, exp_araddr);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      check({tag, "/arvalid_held"}, {31'b0, axi.arvalid}, 32'd1);
      check({tag, "/araddr_held"},  axi.araddr, exp_araddr);
    end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    check({tag, "/arvalid_drop"}, {31'b0, axi.arvalid}, 32'd0);
    check({tag, "/rready"},       {31'b0, axi.rready},  32'd1);
    repeat (r_delay) @(negedge clk);
    axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = rr;
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    finish_resp(tag, exp_rd, exp_err);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input logic [1:0] br,
                          input bit same_cycle, input int aw_delay,
                          input logic [31:0] exp_awaddr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input logic exp_err);
    issue(1'b1, addr, wd, size, 1'b0, tag);
    check({tag, "/awvalid"}, {31'b0, axi.awvalid}, 32'd1);
    check({tag, "/wvalid"},  {31'b0, axi.wvalid},  32'd1);
    check({tag, "/awaddr"},  axi.awaddr, exp_awaddr);
    check({tag, "/wdata"},   axi.wdata,  exp_wdata);
    check({tag, "/wstrb"},   {28'b0, axi.wstrb}, {28'b0, exp_wstrb});
    if (same_cycle) begin
      axi.awready = 1'b1; axi.wready = 1'b1;
      @(negedge clk);
      axi.awready = 1'b0; axi.wready = 1'b0;
    end else begin
      for (int i = 0; i < aw_delay; i++) begin
        @(negedge clk);
        check({tag, "/awvalid_held"}, {31'b0, axi.awvalid}, 32'd1);
        check({tag, "/wvalid_held"},  {31'b0, axi.wvalid},  32'd1);
      end
      axi.awready = 1'b1;
      @(negedge clk);
      axi.awready = 1'b0;
      check({tag, "/awvalid_drop"}, {31'b0, axi.awvalid}, 32'd0);
      check({tag, "/wvalid_after_aw"}, {31'b0, axi.wvalid}, 32'd1);
      check({tag, "/wdata_stable"}, axi.wdata, exp_wdata);
      axi.wready = 1'b1;
      @(negedge clk);
      axi.wready = 1'b0;
    end
    check({tag, "/wvalid_drop"}, {31'b0, axi.wvalid}, 32'd0);
    check({tag, "/bready"},      {31'b0, axi.bready}, 32'd1);
    axi.bvalid = 1'b1; axi.bresp = br;
    @(negedge clk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    finish_resp(tag, 32'h0, exp_err);
  endtask

  task automatic do_bad(input string tag, input logic [31:0] addr, input logic [1:0] size);
    issue(1'b0, addr, 32'h0, size, 1'b0, tag);
    check({tag, "/arvalid"}, {31'b0, axi.arvalid}, 32'd0);
    check({tag, "/awvalid"}, {31'b0, axi.awvalid}, 32'd0);
    finish_resp(tag, 32'h0, 1'b1);
    check({tag, "/arvalid_after"}, {31'b0, axi.arvalid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst/req_ready",  {31'b0, req_ready},   32'd1);
    check("rst/resp_valid", {31'b0, resp_valid},  32'd0);
    check("rst/resp_err",   {31'b0, resp_err},    32'd0);
    check("rst/resp_rdata", resp_rdata,           32'h0);
    check("rst/valids",     {27'b0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
    check("rst/araddr",     axi.araddr,           32'h0);
    check("rst/awaddr",     axi.awaddr,           32'h0);
    check("rst/wdata",      axi.wdata,            32'h0);
    check("rst/wstrb",      {28'b0, axi.wstrb},   32'h0);

    do_load("ld_word", 32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 3,
            32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    do_load("ld_sbyte", 32'h8000_0003, 2'b00, 1'b0, 32'h80AB_CDEF, 2'b00, 2, 0,
            32'h8000_0000, 32'hFFFF_FF80, 1'b0);
    do_load("ld_ubyte", 32'h8000_0003, 2'b00, 1'b1, 32'h80AB_CDEF, 2'b00, 0, 1,
            32'h8000_0000, 32'h0000_0080, 1'b0);
    do_load("ld_shalf_hi", 32'h8000_0012, 2'b01, 1'b0, 32'h80AB_CDEF, 2'b00, 0, 0,
            32'h8000_0010, 32'hFFFF_80AB, 1'b0);
    do_load("ld_uhalf_lo", 32'h8000_0010, 2'b01, 1'b1, 32'h80AB_CDEF, 2'b00, 1, 0,
            32'h8000_0010, 32'h0000_CDEF, 1'b0);
    do_load("ld_rerr", 32'h8000_0020, 2'b10, 1'b0, 32'h1234_5678, 2'b10, 0, 0,
            32'h8000_0020, 32'h0000_0000, 1'b1);

    do_store("st_half", 32'h8000_0102, 32'h0000_1234, 2'b01, 2'b00, 1'b0, 2,
             32'h8000_0100, 32'h1234_1234, 4'b1100, 1'b0);
    do_store("st_byte", 32'h8000_0201, 32'hFFFF_FF5A, 2'b00, 2'b00, 1'b0, 0,
             32'h8000_0200, 32'h5A5A_5A5A, 4'b0010, 1'b0);
    do_store("st_word_same", 32'h8000_0308, 32'h1122_3344, 2'b10, 2'b00, 1'b1, 0,
             32'h8000_0308, 32'h1122_3344, 4'b1111, 1'b0);
    do_store("st_berr", 32'h8000_0400, 32'hCAFE_F00D, 2'b10, 2'b10, 1'b1, 0,
             32'h8000_0400, 32'hCAFE_F00D, 4'b1111, 1'b1);

    do_bad("bad_word", 32'h8000_0001, 2'b10);
    do_bad("bad_half", 32'h8000_0003, 2'b01);
    do_bad("bad_size", 32'h8000_0000, 2'b11);

    // Abandon a load while the DUT waits in RDATA with rvalid low.
    issue(1'b0, 32'h8000_0044, 32'h0, 2'b10, 1'b0, "rst_mid");
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    check("rst_mid/in_rdata", {31'b0, axi.rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid/req_ready",  {31'b0, req_ready},  32'd1);
    check("rst_mid/valids",     {27'b0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
    check("rst_mid/resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("rst_mid/no_resp",    {31'b0, resp_valid}, 32'd0);

    do_load("ld_after_rst", 32'h8000_0048, 2'b10, 1'b1, 32'h0BAD_F00D, 2'b00, 0, 0,
            32'h8000_0048, 32'h0BAD_F00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
